// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: widths, ALU A-source encoding, forward-select constants.
package pipeline_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_ADDR_W   = 5;

  // Encoding 2'b11 is not listed and decodes as rs1.
  typedef enum logic [1:0] {
    SRCA_RS1  = 2'b00,
    SRCA_PC   = 2'b01,
    SRCA_ZERO = 2'b10
  } srca_sel_t;

  localparam int unsigned FWD_NONE = 0;

endpackage

// File: rtl/operand_fwd_sel.sv
// Per-operand forwarding: priority hit search over write-back sources, plus a
// capture register that keeps a forwarded value alive across an EX stall.
module operand_fwd_sel
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned FSEL_W  = $clog2(NUM_FWD + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic                           flush,
  input  logic                           valid_e,
  input  logic [REG_ADDR_W-1:0]          rs_e,
  input  logic [XLEN-1:0]                reg_val,
  input  logic [NUM_FWD-1:0]             fwd_we,
  input  logic [NUM_FWD*REG_ADDR_W-1:0]  fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]        fwd_data,
  output logic [XLEN-1:0]                val_o,
  output logic [FSEL_W-1:0]              fsel_o
);

  logic              hit;
  logic [XLEN-1:0]   hit_data;
  logic [FSEL_W-1:0] hit_sel;

  logic              cap_valid_q, cap_valid_d;
  logic [XLEN-1:0]   cap_data_q, cap_data_d;

  // Lowest-index source that writes rs_e wins; x0 and bubbles never hit.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    hit_sel  = FSEL_W'(FWD_NONE);
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (!hit && fwd_we[k] && valid_e && (rs_e != '0) &&
          (fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] == rs_e)) begin
        hit      = 1'b1;
        hit_data = fwd_data[k*XLEN +: XLEN];
        hit_sel  = FSEL_W'(k + 1);
      end
    end
  end

  // Capture the first forwarded value seen while stalled; drop it when EX moves.
  always_comb begin
    cap_valid_d = cap_valid_q;
    cap_data_d  = cap_data_q;
    if (flush || !stall) begin
      cap_valid_d = 1'b0;
      cap_data_d  = '0;
    end else if (!cap_valid_q && hit) begin
      cap_valid_d = 1'b1;
      cap_data_d  = hit_data;
    end
  end

  // Capture state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid_q <= 1'b0;
      cap_data_q  <= '0;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
    end
  end

  // Captured value overrides any later hit: those writers are younger than this consumer.
  always_comb begin
    val_o  = reg_val;
    fsel_o = FSEL_W'(FWD_NONE);
    if (cap_valid_q) begin
      val_o = cap_data_q;
    end else if (hit) begin
      val_o  = hit_data;
      fsel_o = hit_sel;
    end
  end

endmodule

// File: rtl/ex_operand_unit.sv
// EX-stage operand unit: ID/EX register with stall/flush, per-operand forwarding,
// and ALU A/B source selection.
module ex_operand_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEFAULT,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned FSEL_W  = $clog2(NUM_FWD + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           StallE,
  input  logic                           FlushE,
  input  logic                           ValidD,
  input  logic [XLEN-1:0]                RD1D,
  input  logic [XLEN-1:0]                RD2D,
  input  logic [XLEN-1:0]                ImmExtD,
  input  logic [XLEN-1:0]                PCD,
  input  logic [REG_ADDR_W-1:0]          Rs1D,
  input  logic [REG_ADDR_W-1:0]          Rs2D,
  input  logic [REG_ADDR_W-1:0]          RdD,
  input  logic [1:0]                     ALUSrcAD,
  input  logic                           ALUSrcBD,
  input  logic [NUM_FWD-1:0]             FwdWe,
  input  logic [NUM_FWD*REG_ADDR_W-1:0]  FwdRd,
  input  logic [NUM_FWD*XLEN-1:0]        FwdData,
  output logic [XLEN-1:0]                SrcAE,
  output logic [XLEN-1:0]                SrcBE,
  output logic [XLEN-1:0]                WriteDataE,
  output logic [REG_ADDR_W-1:0]          RdE,
  output logic                           ValidE,
  output logic [FSEL_W-1:0]              ForwardAE,
  output logic [FSEL_W-1:0]              ForwardBE
);

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       rd1;
    logic [XLEN-1:0]       rd2;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [1:0]            alusrca;
    logic                  alusrcb;
  } idex_t;

  idex_t           idex_q, idex_d;
  logic [XLEN-1:0] rs1_val, rs2_val;

  // ID/EX next state: flush beats stall beats load.
  always_comb begin
    idex_d = idex_q;
    if (FlushE) begin
      idex_d = '0;
    end else if (!StallE) begin
      idex_d.valid   = ValidD;
      idex_d.rd1     = RD1D;
      idex_d.rd2     = RD2D;
      idex_d.imm     = ImmExtD;
      idex_d.pc      = PCD;
      idex_d.rs1     = Rs1D;
      idex_d.rs2     = Rs2D;
      idex_d.rd      = RdD;
      idex_d.alusrca = ALUSrcAD;
      idex_d.alusrcb = ALUSrcBD;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  operand_fwd_sel #(
    .XLEN    (XLEN),
    .NUM_FWD (NUM_FWD),
    .FSEL_W  (FSEL_W)
  ) u_fwd_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (StallE),
    .flush    (FlushE),
    .valid_e  (idex_q.valid),
    .rs_e     (idex_q.rs1),
    .reg_val  (idex_q.rd1),
    .fwd_we   (FwdWe),
    .fwd_rd   (FwdRd),
    .fwd_data (FwdData),
    .val_o    (rs1_val),
    .fsel_o   (ForwardAE)
  );

  operand_fwd_sel #(
    .XLEN    (XLEN),
    .NUM_FWD (NUM_FWD),
    .FSEL_W  (FSEL_W)
  ) u_fwd_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (StallE),
    .flush    (FlushE),
    .valid_e  (idex_q.valid),
    .rs_e     (idex_q.rs2),
    .reg_val  (idex_q.rd2),
    .fwd_we   (FwdWe),
    .fwd_rd   (FwdRd),
    .fwd_data (FwdData),
    .val_o    (rs2_val),
    .fsel_o   (ForwardBE)
  );

  // ALU operand muxes; store data is always the resolved rs2.
  always_comb begin
    case (srca_sel_t'(idex_q.alusrca))
      SRCA_PC:   SrcAE = idex_q.pc;
      SRCA_ZERO: SrcAE = '0;
      default:   SrcAE = rs1_val;
    endcase
    SrcBE      = idex_q.alusrcb ? idex_q.imm : rs2_val;
    WriteDataE = rs2_val;
    RdE        = idex_q.rd;
    ValidE     = idex_q.valid;
  end

endmodule
